cfg_bitstream_tx: RTL

- Host-side serializer for the tile configuration chain. It drives `cfg_in_start` and `cfg_bit_in` into the first tile's configuration block.
- Accepts the configuration image as WORD_W-bit words over a valid/ready stream. Emits one start pulse, then exactly CFG_SIZE bits, LSB first, one bit per clk.
- The image already contains the target tile ID field in its top bits; this block does not interpret it.
- Replaces bench-driven bit-banging in chip-level configuration.

---
 rtl/cfg_bitstream_tx.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/cfg_bitstream_tx.sv
// Host-side serializer for the tile configuration chain: takes WORD_W-bit words
// over valid/ready and emits a start pulse followed by CFG_SIZE bits, LSB first.
module cfg_bitstream_tx #(
    parameter int CFG_SIZE    = 256,
    parameter int WORD_W      = 32,
    parameter int TAIL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              crst,
    input  logic              go,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              cfg_in_start,
    output logic              cfg_bit_in,
    output logic              busy,
    output logic              done,
    output logic              underrun
);
    localparam int NWORDS = (CFG_SIZE + WORD_W - 1) / WORD_W;
    localparam int BW     = $clog2(CFG_SIZE + 1);
    localparam int WBW    = $clog2(WORD_W + 1);
    localparam int AW     = $clog2(NWORDS + 1);
    localparam int TW     = $clog2(TAIL_CYCLES + 2);

    localparam logic [BW-1:0]  LAST_BIT = BW'(CFG_SIZE - 1);
    localparam logic [WBW-1:0] WORD_END = WBW'(WORD_W - 1);
    localparam logic [AW-1:0]  ALL_WORDS = AW'(NWORDS);
    localparam logic [TW-1:0]  TAIL_END = TW'(TAIL_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_START,
        S_SHIFT,
        S_TAIL
    } state_t;

    state_t            state, state_n;
    logic [WORD_W-1:0] sr, sr_n;
    logic [WORD_W-1:0] hold, hold_n;
    logic              hv, hv_n;
    logic [BW-1:0]     bcnt, bcnt_n;
    logic [WBW-1:0]    wbit, wbit_n;
    logic [AW-1:0]     acnt, acnt_n;
    logic [TW-1:0]     tcnt, tcnt_n;
    logic              done_n, underrun_n;
    logic              accept;

    assign s_ready = (state == S_WAIT || state == S_START || state == S_SHIFT)
                     && !hv && (acnt != ALL_WORDS);
    assign accept  = s_valid && s_ready;

    always_comb begin
        state_n    = state;
        sr_n       = sr;
        hold_n     = hold;
        hv_n       = hv;
        bcnt_n     = bcnt;
        wbit_n     = wbit;
        acnt_n     = acnt;
        tcnt_n     = tcnt;
        done_n     = 1'b0;
        underrun_n = 1'b0;

        case (state)
            S_IDLE: begin
                if (go) begin
                    state_n = S_WAIT;
                    acnt_n  = '0;
                end
            end
            S_WAIT: begin
                if (hv) state_n = S_START;
            end
            S_START: begin
                sr_n    = hold;
                hv_n    = 1'b0;
                bcnt_n  = '0;
                wbit_n  = '0;
                state_n = S_SHIFT;
            end
            S_SHIFT: begin
                sr_n = sr >> 1;
                if (bcnt == LAST_BIT) begin
                    if (TAIL_CYCLES == 0) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        state_n = S_TAIL;
                        tcnt_n  = '0;
                    end
                end else begin
                    bcnt_n = bcnt + 1'b1;
                    // Word boundary: reload from hold on this edge for a gapless stream.
                    if (wbit == WORD_END) begin
                        if (hv) begin
                            sr_n   = hold;
                            hv_n   = 1'b0;
                            wbit_n = '0;
                        end else begin
                            state_n    = S_IDLE;
                            underrun_n = 1'b1;
                        end
                    end else begin
                        wbit_n = wbit + 1'b1;
                    end
                end
            end
            S_TAIL: begin
                if (tcnt == TAIL_END) begin
                    state_n = S_IDLE;
                    done_n  = 1'b1;
                end else begin
                    tcnt_n = tcnt + 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Applied last so a same-edge accept wins over the hold->sr transfer clear.
        if (accept) begin
            hold_n = s_data;
            hv_n   = 1'b1;
            acnt_n = acnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!crst) begin
            state        <= S_IDLE;
            sr           <= '0;
            hold         <= '0;
            hv           <= 1'b0;
            bcnt         <= '0;
            wbit         <= '0;
            acnt         <= '0;
            tcnt         <= '0;
            cfg_in_start <= 1'b0;
            cfg_bit_in   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            state        <= state_n;
            sr           <= sr_n;
            hold         <= hold_n;
            hv           <= hv_n;
            bcnt         <= bcnt_n;
            wbit         <= wbit_n;
            acnt         <= acnt_n;
            tcnt         <= tcnt_n;
            cfg_in_start <= (state_n == S_START);
            cfg_bit_in   <= (state_n == S_SHIFT) && sr_n[0];
            busy         <= (state_n != S_IDLE);
            done         <= done_n;
            underrun     <= underrun_n;
        end
    end
endmodule
